// File: rtl/rx_pkg.sv
// rx_demux shared definitions.
// Default geometry and receive FSM state encoding.
package rx_pkg;

  localparam int RX_NUM_SW_INST  = 5;
  localparam int RX_W_WIDTH      = 8;
  localparam int RX_FRAME_WIDTH  = 32;
  localparam int WORDS_PER_FRAME = RX_FRAME_WIDTH / RX_W_WIDTH;
  localparam int CNT_W           = $clog2(WORDS_PER_FRAME);

  typedef enum logic {
    COLLECT  = 1'b0,
    DISPATCH = 1'b1
  } rx_state_e;

  function automatic int words_per_frame(input int fw, input int ww);
    return fw / ww;
  endfunction

endpackage

// File: rtl/rx_addr_match.sv
// Lowest-index priority match of an address word
// against the per-instance configured unit addresses.
module rx_addr_match
  import rx_pkg::*;
#(
  parameter int NUM_SW_INST = RX_NUM_SW_INST,
  parameter int W_WIDTH     = RX_W_WIDTH
) (
  input  logic [W_WIDTH-1:0]             i_addr,
  input  logic [W_WIDTH*NUM_SW_INST-1:0] i_addr_cfg,
  output logic [NUM_SW_INST-1:0]         o_sel,
  output logic                           o_hit
);

  // Scan high to low so the lowest matching index is written last
  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    for (int i = NUM_SW_INST - 1; i >= 0; i--) begin
      if (i_addr_cfg[i*W_WIDTH +: W_WIDTH] == i_addr) begin
        o_sel    = '0;
        o_sel[i] = 1'b1;
      end
    end
    o_hit = |o_sel;
  end

endmodule

// File: rtl/rx_demux.sv
// Receive demux: assembles link words into frames and
// delivers each to the instance its address word selects.
module rx_demux
  import rx_pkg::*;
#(
  parameter int NUM_SW_INST = RX_NUM_SW_INST,
  parameter int W_WIDTH     = RX_W_WIDTH,
  parameter int FRAME_WIDTH = RX_FRAME_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [W_WIDTH-1:0]                 data_in,
  input  logic                               valid_in,
  output logic                               ready_out,
  input  logic [W_WIDTH*NUM_SW_INST-1:0]     addr_cfg,
  output logic [FRAME_WIDTH*NUM_SW_INST-1:0] data_out,
  output logic [NUM_SW_INST-1:0]             valid_out,
  input  logic [NUM_SW_INST-1:0]             ready_in,
  output logic                               drop_pulse,
  output logic                               busy
);

  localparam int N  = words_per_frame(FRAME_WIDTH, W_WIDTH);
  localparam int CW = $clog2(N);

  rx_state_e              r_state, w_nx_state;
  logic [CW-1:0]          r_cnt, w_nx_cnt;
  logic [FRAME_WIDTH-1:0] r_frame, w_nx_frame;
  logic [NUM_SW_INST-1:0] r_sel, w_nx_sel;
  logic                   r_miss, w_nx_miss;
  logic [NUM_SW_INST-1:0] r_valid, w_nx_valid;
  logic                   r_drop, w_nx_drop;
  logic                   r_ready, w_nx_ready;

  logic [NUM_SW_INST-1:0] w_sel;
  logic                   w_hit;
  logic                   w_acc;
  logic                   w_last;

  rx_addr_match #(
    .NUM_SW_INST (NUM_SW_INST),
    .W_WIDTH     (W_WIDTH)
  ) u_match (
    .i_addr     (data_in),
    .i_addr_cfg (addr_cfg),
    .o_sel      (w_sel),
    .o_hit      (w_hit)
  );

  assign w_acc  = valid_in && r_ready;
  assign w_last = (r_cnt == CW'(N - 1));

  // Next-state and next-register logic for the receive FSM
  always_comb begin
    w_nx_state = r_state;
    w_nx_cnt   = r_cnt;
    w_nx_frame = r_frame;
    w_nx_sel   = r_sel;
    w_nx_miss  = r_miss;
    w_nx_valid = r_valid;
    w_nx_drop  = 1'b0;
    w_nx_ready = r_ready;
    unique case (r_state)
      COLLECT: begin
        w_nx_ready = 1'b1;
        if (w_acc) begin
          for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
              w_nx_frame[FRAME_WIDTH-1-k*W_WIDTH -: W_WIDTH] = data_in;
            end
          end
          if (r_cnt == '0) begin
            w_nx_sel  = w_sel;
            w_nx_miss = !w_hit;
          end
          if (w_last) begin
            w_nx_cnt = '0;
            if (r_miss) begin
              w_nx_drop = 1'b1;
            end else begin
              w_nx_state = DISPATCH;
              w_nx_ready = 1'b0;
              w_nx_valid = r_sel;
            end
          end else begin
            w_nx_cnt = r_cnt + 1'b1;
          end
        end
      end
      DISPATCH: begin
        w_nx_ready = 1'b0;
        if (|(r_valid & ready_in)) begin
          w_nx_valid = '0;
          w_nx_state = COLLECT;
          w_nx_ready = 1'b1;
        end
      end
      default: begin
        w_nx_state = COLLECT;
      end
    endcase
  end

  // State and datapath registers; reset discards any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
      r_frame <= '0;
      r_sel   <= '0;
      r_miss  <= 1'b0;
      r_valid <= '0;
      r_drop  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_cnt   <= w_nx_cnt;
      r_frame <= w_nx_frame;
      r_sel   <= w_nx_sel;
      r_miss  <= w_nx_miss;
      r_valid <= w_nx_valid;
      r_drop  <= w_nx_drop;
      r_ready <= w_nx_ready;
    end
  end

  assign ready_out  = r_ready;
  assign data_out   = {NUM_SW_INST{r_frame}};
  assign valid_out  = r_valid;
  assign drop_pulse = r_drop;
  assign busy       = (r_state == DISPATCH);

endmodule

// File: tb/tb_rx_demux.sv
// Directed self-checking bench for rx_demux.
// Linear scenario sequence with immediate-assert checks.
module tb_rx_demux;

  localparam int NI = 5;
  localparam int WW = 8;
  localparam int FW = 32;

  logic             clk;
  logic             rst;
  logic [WW-1:0]    data_in;
  logic             valid_in;
  logic             ready_out;
  logic [WW*NI-1:0] addr_cfg;
  logic [FW*NI-1:0] data_out;
  logic [NI-1:0]    valid_out;
  logic [NI-1:0]    ready_in;
  logic             drop_pulse;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;

  rx_demux #(
    .NUM_SW_INST (NI),
    .W_WIDTH     (WW),
    .FRAME_WIDTH (FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .addr_cfg   (addr_cfg),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .drop_pulse (drop_pulse),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [WW-1:0] w);
    valid_in = 1'b1;
    data_in  = w;
    tick();
    valid_in = 1'b0;
    data_in  = 8'h5A;
  endtask

  task automatic set_cfg(input int i, input logic [WW-1:0] a);
    addr_cfg[i*WW +: WW] = a;
  endtask

  function automatic logic [FW-1:0] slice(input int i);
    return data_out[i*FW +: FW];
  endfunction

  initial begin
    rst      = 1'b1;
    data_in  = '0;
    valid_in = 1'b0;
    ready_in = '0;
    addr_cfg = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    #3;
    chk("rst_ready", 64'(ready_out), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_drop", 64'(drop_pulse), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(data_out == '0), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("ready_rise", 64'(ready_out), 64'd1);

    // scenario 1
    set_cfg(3, 8'h03);
    ready_in = 5'b01000;
    send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
    chk("s1_valid", 64'(valid_out), 64'h08);
    chk("s1_data3", 64'(slice(3)), 64'h03AABBCC);
    chk("s1_data0", 64'(slice(0)), 64'h03AABBCC);
    chk("s1_busy", 64'(busy), 64'd1);
    chk("s1_rdy_lo", 64'(ready_out), 64'd0);
    tick();
    chk("s1_valid_clr", 64'(valid_out), 64'd0);
    chk("s1_rdy_hi", 64'(ready_out), 64'd1);
    chk("s1_busy_clr", 64'(busy), 64'd0);

    // scenario 2: backpressure, others' ready ignored
    ready_in = 5'b00000;
    send(8'h03); send(8'hDD); send(8'hEE); send(8'hFF);
    ready_in = 5'b10111;
    valid_in = 1'b1;
    data_in  = 8'h99;
    for (int i = 0; i < 10; i++) begin
      chk("s2_hold_valid", 64'(valid_out), 64'h08);
      chk("s2_hold_rdy", 64'(ready_out), 64'd0);
      chk("s2_hold_data", 64'(slice(3)), 64'h03DDEEFF);
      tick();
    end
    ready_in = 5'b01000;
    tick();
    valid_in = 1'b0;
    chk("s2_deliv", 64'(valid_out), 64'd0);
    chk("s2_rdy", 64'(ready_out), 64'd1);
    send(8'h03); send(8'h12); send(8'h34); send(8'h56);
    chk("s2_next_valid", 64'(valid_out), 64'h08);
    chk("s2_next_data", 64'(slice(3)), 64'h03123456);
    tick();
    chk("s2_next_clr", 64'(valid_out), 64'd0);

    // scenario 3: drop, then back-to-back frame
    set_cfg(2, 8'h02);
    ready_in = 5'b00100;
    send(8'h7F);
    chk("s3_rdy0", 64'(ready_out), 64'd1);
    send(8'h01); send(8'h02);
    chk("s3_nodrop", 64'(drop_pulse), 64'd0);
    send(8'h03);
    chk("s3_drop", 64'(drop_pulse), 64'd1);
    chk("s3_valid", 64'(valid_out), 64'd0);
    chk("s3_rdy", 64'(ready_out), 64'd1);
    chk("s3_busy", 64'(busy), 64'd0);
    send(8'h02);
    chk("s3_drop_end", 64'(drop_pulse), 64'd0);
    send(8'h11); send(8'h22); send(8'h33);
    chk("s3_valid2", 64'(valid_out), 64'h04);
    chk("s3_data2", 64'(slice(2)), 64'h02112233);
    tick();
    chk("s3_clr", 64'(valid_out), 64'd0);

    // scenario 4: duplicate address, lowest index wins
    set_cfg(1, 8'h05);
    set_cfg(4, 8'h05);
    ready_in = 5'b10010;
    send(8'h05); send(8'h01); send(8'h02); send(8'h03);
    chk("s4_valid", 64'(valid_out), 64'h02);
    chk("s4_data", 64'(slice(1)), 64'h05010203);
    tick();
    chk("s4_clr", 64'(valid_out), 64'd0);

    // scenario 5: idle bubbles between words
    ready_in = 5'b01000;
    send(8'h03);
    repeat (3) tick();
    send(8'hAA);
    repeat (3) tick();
    send(8'hBB);
    repeat (3) tick();
    chk("s5_pending", 64'(valid_out), 64'd0);
    send(8'hCC);
    chk("s5_valid", 64'(valid_out), 64'h08);
    chk("s5_data", 64'(slice(3)), 64'h03AABBCC);
    tick();
    chk("s5_clr", 64'(valid_out), 64'd0);

    // scenario 6: mid-frame reset, cfg change after word 0
    send(8'h03);
    set_cfg(3, 8'h44);
    send(8'hAA);
    set_cfg(3, 8'h03);
    rst = 1'b1;
    #1;
    chk("s6_ready", 64'(ready_out), 64'd0);
    chk("s6_valid", 64'(valid_out), 64'd0);
    chk("s6_drop", 64'(drop_pulse), 64'd0);
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_data", 64'(data_out == '0), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("s6_rdy_rise", 64'(ready_out), 64'd1);
    chk("s6_no_drop", 64'(drop_pulse), 64'd0);
    send(8'h03);
    set_cfg(3, 8'h77);
    send(8'h01); send(8'h02); send(8'h03);
    chk("s6_valid2", 64'(valid_out), 64'h08);
    chk("s6_data2", 64'(slice(3)), 64'h03010203);
    chk("s6_drop2", 64'(drop_pulse), 64'd0);
    tick();
    chk("s6_clr", 64'(valid_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_demux.md
Name: rx_demux

Overview:
Receive-side counterpart of the TX frame mux, sitting between the shared link input and the NUM_SW_INST switch instances.
- Assembles W_WIDTH-wide words from a single valid/ready stream into FRAME_WIDTH frames.
- Decodes the first word as the destination unit address against per-instance configured addresses.
- Delivers each frame to exactly one instance with a one-hot valid/ready handshake, or drops it if no address matches.

Parameters:
NUM_SW_INST, 5, number of switch instances (output slices)
W_WIDTH, 8, input word width and unit-address width
FRAME_WIDTH, 32, frame width; integer multiple of W_WIDTH and at least 2*W_WIDTH

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
data_in  in  W_WIDTH  input word
valid_in  in  1  data_in valid
ready_out  out  1  word accepted when valid_in && ready_out
addr_cfg  in  W_WIDTH*NUM_SW_INST  unit address of instance i at slice [i*W_WIDTH +: W_WIDTH]
data_out  out  FRAME_WIDTH*NUM_SW_INST  assembled frame, replicated on every slice
valid_out  out  NUM_SW_INST  one-hot; bit i = frame pending for instance i
ready_in  in  NUM_SW_INST  instance i accepts the frame
drop_pulse  out  1  one-cycle pulse per discarded frame
busy  out  1  high while a frame waits for delivery

Behaviour:
- Reset values (async assert): ready_out=0, data_out=0, valid_out=0, drop_pulse=0, busy=0, state=COLLECT, word count=0. ready_out rises on the first clk edge after rst deasserts.
- N = FRAME_WIDTH/W_WIDTH words per frame, MSB-first: word k lands at [FRAME_WIDTH-1-k*W_WIDTH -: W_WIDTH].
- Word 0 is the address.
  - On its acceptance, compare against all addr_cfg slices and register a one-hot sel.
  - If several slices match, the lowest index wins. If none match, flag the frame for drop.
  - addr_cfg is sampled only at word 0; later changes do not affect the current frame.
- COLLECT state:
  - ready_out=1; the word counter increments on each accepted word.
  - valid_in bubbles between words are allowed and do not change the result.
- On the word N-1 accepted edge:
  - Matched frame: next state DISPATCH, ready_out=0, valid_out=sel, busy=1. valid_out is therefore asserted the cycle after the last word.
  - Dropped frame: drop_pulse=1 for exactly that next cycle, valid_out stays 0, state stays COLLECT with ready_out=1. A following frame is accepted back-to-back.
- DISPATCH state:
  - data_out and valid_out are held stable. valid_in is ignored, and data_in may be X.
  - ready_in bits of non-selected instances are ignored.
  - On valid_out[i] && ready_in[i]: next cycle valid_out=0, busy=0, ready_out=1, state COLLECT. There is one bubble cycle between delivery and the next accepted word.
- data_out retains the last frame after delivery; only valid_out qualifies it.
- Reset mid-frame or mid-dispatch: the partial or pending frame is discarded and the counter cleared. No drop_pulse is generated.
- Word counter: $clog2(N) bits, wraps to 0 after word N-1.

Decomposition:
- Package rx_pkg:
  - WORDS_PER_FRAME = FRAME_WIDTH/W_WIDTH
  - CNT_W = $clog2(WORDS_PER_FRAME)
  - state encoding {COLLECT, DISPATCH}
- Sub-module rx_addr_match: combinational lowest-index priority compare of the address word against addr_cfg, producing a one-hot sel plus a hit flag. rx_demux registers its outputs.

Test Plan:
1. Reset, then addr_cfg slice3=0x03, send words 03,AA,BB,CC with ready_in=5'b01000 -> valid_out=5'b01000 one cycle after the 4th word, data_out slice = 0x03AABBCC; next cycle valid_out=0 and ready_out=1.
2. Same frame with ready_in=0 for 10 cycles while offering more words -> ready_out=0 and valid_out/data_out held throughout, offered words not consumed; after ready_in[3]=1, delivery completes and the following frame decodes correctly.
3. Address 0x7F with no match -> drop_pulse high exactly one cycle after the 4th word, valid_out stays 0, ready_out never drops; next frame 02,11,22,33 with slice2=0x02 is delivered on valid_out[2].
4. Slices 1 and 4 both configured 0x05, frame 05,.. -> valid_out=5'b00010.
5. Frame 03,AA,BB,CC with 3 idle cycles between each word -> identical response to scenario 1.
6. Assert rst after 2 words -> all outputs 0 immediately, no drop_pulse; after release, a complete fresh frame decodes and delivers normally.
